bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_add3.sv | 16 +
 rtl/bcd_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_bcd_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// BCD_LZB_EN (leading-zero blanking) uses the blank code and helper defined here.
package bcd_pkg;

  localparam int IN_W     = 10;
  localparam int N_DIGITS = 4;
  localparam int N_ITER   = 10;
  localparam int ACC_W    = 4 * N_DIGITS;
  localparam int CNT_W    = 4;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Replace leading zero digits (thousands down to tens) with the blank code.
  function automatic logic [ACC_W-1:0] bcd_blank(input logic [ACC_W-1:0] digits);
    logic [ACC_W-1:0] r;
    logic             lead;
    r    = digits;
    lead = 1'b1;
    for (int d = N_DIGITS - 1; d >= 1; d--) begin
      if (lead && (digits[4*d +: 4] == 4'd0)) begin
        r[4*d +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Purely combinational correction; no carry leaves the digit.
  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential 10-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Define BCD_LZB_EN to blank leading zero digits out3..out1 with 4'hF.
module bcd_seq_ctrl #(
  parameter int IN_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out0,
  output logic [3:0]      out1,
  output logic [3:0]      out2,
  output logic [3:0]      out3,
  output logic            busy
);
  import bcd_pkg::*;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    sreg_q, sreg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic               valid_q, busy_q;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic [ACC_W-1:0]   res_next_s;
  logic               accept_s;
  logic               last_iter_s;

  bcd_add3 u_add3_d0 (.digit_i(acc_q[3:0]),   .digit_o(acc_adj_s[3:0]));
  bcd_add3 u_add3_d1 (.digit_i(acc_q[7:4]),   .digit_o(acc_adj_s[7:4]));
  bcd_add3 u_add3_d2 (.digit_i(acc_q[11:8]),  .digit_o(acc_adj_s[11:8]));
  bcd_add3 u_add3_d3 (.digit_i(acc_q[15:12]), .digit_o(acc_adj_s[15:12]));

  // Corrected accumulator shifted left with the next binary bit entering at bit 0.
  always_comb begin
    acc_shift_s = {acc_adj_s[ACC_W-2:0], sreg_q[IN_W-1]};
    last_iter_s = (cnt_q == CNT_W'(N_ITER - 1));
`ifdef BCD_LZB_EN
    res_next_s  = bcd_blank(acc_shift_s);
`else
    res_next_s  = acc_shift_s;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE can hand straight over to a new conversion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_iter_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready && in_valid) begin
          state_d = SHIFT;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake ready and the digit/flag ports.
  always_comb begin
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      SHIFT:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
    accept_s  = in_valid & in_ready;
    out_valid = valid_q;
    busy      = busy_q;
    out0      = res_q[3:0];
    out1      = res_q[7:4];
    out2      = res_q[11:8];
    out3      = res_q[15:12];
  end

  // Datapath next-state: load on accept, one double-dabble step per SHIFT cycle.
  always_comb begin
    sreg_d = sreg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    if (accept_s) begin
      sreg_d = in_data;
      acc_d  = {ACC_W{1'b0}};
      cnt_d  = {CNT_W{1'b0}};
    end else if (state_q == SHIFT) begin
      acc_d  = acc_shift_s;
      sreg_d = {sreg_q[IN_W-2:0], 1'b0};
      if (last_iter_s) begin
        cnt_d = {CNT_W{1'b0}};
        res_d = res_next_s;
      end else begin
        cnt_d = cnt_q + 4'd1;
        res_d = res_q;
      end
    end else begin
      sreg_d = sreg_q;
      acc_d  = acc_q;
    end
  end

  // Datapath and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q  <= {IN_W{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      res_q   <= {ACC_W{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d == SHIFT);
    end
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed self-checking bench for bcd_seq_ctrl; expectations follow BCD_LZB_EN when defined.
module tb_bcd_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out0, out1, out2, out3;
  logic       busy;

  int checks;
  int errors;

  bcd_seq_ctrl #(.IN_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BCD_LZB_EN
  localparam logic [15:0] EXP_0    = 16'hFFF0;
  localparam logic [15:0] EXP_999  = 16'hF999;
  localparam logic [15:0] EXP_5    = 16'hFFF5;
  localparam logic [15:0] EXP_640  = 16'hF640;
  localparam logic [15:0] EXP_42   = 16'hFF42;
  localparam logic [15:0] EXP_321  = 16'hF321;
`else
  localparam logic [15:0] EXP_0    = 16'h0000;
  localparam logic [15:0] EXP_999  = 16'h0999;
  localparam logic [15:0] EXP_5    = 16'h0005;
  localparam logic [15:0] EXP_640  = 16'h0640;
  localparam logic [15:0] EXP_42   = 16'h0042;
  localparam logic [15:0] EXP_321  = 16'h0321;
`endif
  localparam logic [15:0] EXP_1023 = 16'h1023;

  function automatic logic [15:0] digits();
    return {out3, out2, out1, out0};
  endfunction

  // Present v for one cycle from IDLE; returns half a cycle after the accept edge.
  task automatic send(input logic [9:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 10'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || digits() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b digits=%h, required 0 0 0000", out_valid, busy, digits());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_single(input logic [9:0] v, input logic [15:0] exp, input string tag);
    int c;
    out_ready = 1'b1;
    send(v);
    wait_valid(c);
    checks++;
    if (c !== 10) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required 10", tag, c);
    end
    checks++;
    if (digits() !== exp) begin
      errors++;
      $display("FAIL %s_digits: got %h, required %h", tag, digits(), exp);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || digits() !== exp) begin
      errors++;
      $display("FAIL %s_to_idle: valid=%b busy=%b ready=%b digits=%h, required 0 0 1 %h",
               tag, out_valid, busy, in_ready, digits(), exp);
    end
  endtask

  task automatic test_back_to_back();
    int c, c2;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 10'd5;
    @(negedge clk);
    in_data  = 10'd640;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_shift_flags: ready=%b busy=%b, required 0 1", in_ready, busy);
    end
    wait_valid(c);
    checks++;
    if (c !== 10 || digits() !== EXP_5) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d digits=%h, required 10 %h", c, digits(), EXP_5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_same_edge_accept: valid=%b busy=%b, required 0 1", out_valid, busy);
    end
    wait_valid(c2);
    c2 = c2 + 1;
    checks++;
    if (c2 !== 11 || digits() !== EXP_640) begin
      errors++;
      $display("FAIL b2b_second: spacing=%0d digits=%h, required 11 %h", c2, digits(), EXP_640);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    int c;
    out_ready = 1'b0;
    send(10'd42);
    wait_valid(c);
    checks++;
    if (c !== 10 || digits() !== EXP_42) begin
      errors++;
      $display("FAIL hold_result: cycles=%0d digits=%h, required 10 %h", c, digits(), EXP_42);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || digits() !== EXP_42) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b digits=%h, required 1 0 %h",
                 k, out_valid, in_ready, digits(), EXP_42);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b busy=%b ready=%b, required 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic seen;
    out_ready = 1'b1;
    send(10'd777);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got %b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || digits() !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_clear: busy=%b valid=%b digits=%h, required 0 0 0000", busy, out_valid, digits());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b, required 1", in_ready);
    end
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_valid: activity seen=%b, required 0", seen);
    end
  endtask

  task automatic test_data_change();
    int c;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 10'd321;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 30) begin
      in_data = 10'd900 + 10'(c);
      @(negedge clk);
      c++;
    end
    checks++;
    if (c !== 10 || digits() !== EXP_321) begin
      errors++;
      $display("FAIL data_change: cycles=%0d digits=%h, required 10 %h", c, digits(), EXP_321);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single(10'd0,    EXP_0,    "zero");
    test_single(10'd1023, EXP_1023, "max");
    test_single(10'd999,  EXP_999,  "v999");
    test_back_to_back();
    test_hold();
    test_reset_mid_shift();
    test_data_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
